// File: rtl/dwc_lpddr5xphy_pclk_rpt_seq.sv
// PCLK repeater-chain power sequencer: ramps segment gates up/down
// one at a time with a programmable settle gap, safe-off on supply loss.
module dwc_lpddr5xphy_pclk_rpt_seq #(
  parameter int NUM_SEG = 4,
  parameter int DLY_W   = 6
) (
  input  logic               Pclk,
  input  logic               Reset_n,
  input  logic               PwrOk,
  input  logic               EnReq,
  input  logic [DLY_W-1:0]   SettleDly,
  output logic [NUM_SEG-1:0] SegEn,
  output logic               PclkRdy,
  output logic               Busy,
  output logic               PwrFault
);

  localparam int IW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SEG - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_UP,
    S_ON,
    S_DOWN,
    S_FAULT
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DLY_W-1:0]  cnt;
  logic [DLY_W-1:0]  dly_q;
  logic [1:0]        sync_q;
  logic              pwr_ok_s;
  logic              live;

  // Segments 0..n-1 on; keeps SegEn thermometer-coded by construction
  function automatic logic [NUM_SEG-1:0] therm(input int n);
    logic [NUM_SEG-1:0] t;
    for (int i = 0; i < NUM_SEG; i++) begin
      t[i] = (i < n);
    end
    return t;
  endfunction

  always_ff @(posedge Pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], PwrOk};
    end
  end

  assign pwr_ok_s = sync_q[1];
  assign live = (state == S_UP) ||
                (state == S_ON) ||
                (state == S_DOWN);

  always_ff @(posedge Pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_OFF;
      idx      <= '0;
      cnt      <= '0;
      dly_q    <= '0;
      SegEn    <= '0;
      PclkRdy  <= 1'b0;
      Busy     <= 1'b0;
      PwrFault <= 1'b0;
    end else if (live && !pwr_ok_s) begin
      // Supply loss overrides any ramp in flight
      state    <= S_FAULT;
      idx      <= '0;
      cnt      <= '0;
      SegEn    <= '0;
      PclkRdy  <= 1'b0;
      Busy     <= 1'b0;
      PwrFault <= 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          SegEn   <= '0;
          PclkRdy <= 1'b0;
          if (EnReq && pwr_ok_s) begin
            state <= S_UP;
            SegEn <= therm(1);
            idx   <= '0;
            cnt   <= SettleDly;
            dly_q <= SettleDly;
            Busy  <= 1'b1;
          end
        end
        S_UP: begin
          if (!EnReq) begin
            state <= S_DOWN;
            cnt   <= SettleDly;
            dly_q <= SettleDly;
          end else if (cnt != '0) begin
            cnt <= cnt - DLY_W'(1);
          end else if (idx != LAST) begin
            idx   <= idx + IW'(1);
            SegEn <= therm(int'(idx) + 2);
            cnt   <= dly_q;
          end else begin
            state   <= S_ON;
            PclkRdy <= 1'b1;
            Busy    <= 1'b0;
          end
        end
        S_ON: begin
          SegEn <= '1;
          if (!EnReq) begin
            state   <= S_DOWN;
            idx     <= LAST;
            cnt     <= SettleDly;
            dly_q   <= SettleDly;
            PclkRdy <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        S_DOWN: begin
          if (cnt != '0) begin
            cnt <= cnt - DLY_W'(1);
          end else begin
            SegEn <= therm(int'(idx));
            if (idx == '0) begin
              state <= S_OFF;
              Busy  <= 1'b0;
            end else begin
              idx <= idx - IW'(1);
              cnt <= dly_q;
            end
          end
        end
        S_FAULT: begin
          SegEn   <= '0;
          PclkRdy <= 1'b0;
          Busy    <= 1'b0;
          if (!EnReq) begin
            state    <= S_OFF;
            PwrFault <= 1'b0;
          end
        end
        default: begin
          state    <= S_OFF;
          idx      <= '0;
          cnt      <= '0;
          SegEn    <= '0;
          PclkRdy  <= 1'b0;
          Busy     <= 1'b0;
          PwrFault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dwc_lpddr5xphy_pclk_rpt_seq.sv
// Bench for the PCLK repeater sequencer: directed ramps plus random
// traffic, checked every cycle against a segment-count model.
module tb_dwc_lpddr5xphy_pclk_rpt_seq;

  localparam int NS = 4;
  localparam int DW = 6;

  logic          Pclk = 1'b0;
  logic          Reset_n;
  logic          PwrOk;
  logic          EnReq;
  logic [DW-1:0] SettleDly;
  logic [NS-1:0] SegEn;
  logic          PclkRdy;
  logic          Busy;
  logic          PwrFault;

  int n_cmp = 0;
  int n_bad = 0;

  dwc_lpddr5xphy_pclk_rpt_seq #(
    .NUM_SEG(NS),
    .DLY_W(DW)
  ) dut (
    .Pclk(Pclk),
    .Reset_n(Reset_n),
    .PwrOk(PwrOk),
    .EnReq(EnReq),
    .SettleDly(SettleDly),
    .SegEn(SegEn),
    .PclkRdy(PclkRdy),
    .Busy(Busy),
    .PwrFault(PwrFault)
  );

  always #5 Pclk = ~Pclk;

  // Model: number of lit segments plus edges left until the next step
  typedef enum {M_OFF, M_UP, M_ON, M_DN, M_FLT} mode_t;
  mode_t m_mode;
  int    m_k;
  int    m_left;
  int    m_dly;
  bit    m_flt;
  bit    p1, p2;

  always @(posedge Pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = M_OFF;
      m_k = 0;
      m_left = 0;
      m_dly = 0;
      m_flt = 0;
      p1 = 0;
      p2 = 0;
    end else begin
      bit ps;
      ps = p2;
      p2 = p1;
      p1 = PwrOk;
      if (m_mode inside {M_UP, M_ON, M_DN} && !ps) begin
        m_mode = M_FLT;
        m_k = 0;
        m_flt = 1;
      end else begin
        case (m_mode)
          M_OFF:
            if (EnReq && ps) begin
              m_mode = M_UP;
              m_k = 1;
              m_dly = int'(SettleDly);
              m_left = m_dly + 1;
            end
          M_UP:
            if (!EnReq) begin
              m_mode = M_DN;
              m_dly = int'(SettleDly);
              m_left = m_dly + 1;
            end else begin
              m_left--;
              if (m_left == 0) begin
                if (m_k == NS) m_mode = M_ON;
                else begin
                  m_k++;
                  m_left = m_dly + 1;
                end
              end
            end
          M_ON:
            if (!EnReq) begin
              m_mode = M_DN;
              m_dly = int'(SettleDly);
              m_left = m_dly + 1;
            end
          M_DN: begin
            m_left--;
            if (m_left == 0) begin
              m_k--;
              m_left = m_dly + 1;
              if (m_k == 0) m_mode = M_OFF;
            end
          end
          M_FLT:
            if (!EnReq) begin
              m_mode = M_OFF;
              m_flt = 0;
            end
          default: m_mode = M_OFF;
        endcase
      end
    end
  end

  always @(negedge Pclk) begin
    logic [NS-1:0] e_seg;
    logic e_rdy, e_busy, e_flt;
    e_seg = NS'((1 << m_k) - 1);
    e_rdy = (m_mode == M_ON);
    e_busy = (m_mode == M_UP) || (m_mode == M_DN);
    e_flt = m_flt;
    n_cmp++;
    if (SegEn !== e_seg || PclkRdy !== e_rdy ||
        Busy !== e_busy || PwrFault !== e_flt) begin
      n_bad++;
      $display("FAIL model t=%0t seg=%b/%b rdy=%b/%b busy=%b/%b flt=%b/%b",
               $time, SegEn, e_seg, PclkRdy, e_rdy,
               Busy, e_busy, PwrFault, e_flt);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Pclk);
  endtask

  initial begin
    int pdrop;
    Reset_n = 1'b0;
    PwrOk = 1'b0;
    EnReq = 1'b0;
    SettleDly = '0;
    #2;
    chk("rst_seg", int'(SegEn), 0);
    chk("rst_rdy", int'(PclkRdy), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_flt", int'(PwrFault), 0);
    step(2);
    Reset_n = 1'b1;
    PwrOk = 1'b1;
    step(3);

    // Ramp up, settle 3
    SettleDly = 6'd3;
    EnReq = 1'b1;
    step(1);
    chk("up_t0", int'(SegEn), 4'b0001);
    chk("up_busy", int'(Busy), 1);
    SettleDly = 6'd9;
    step(4);
    chk("up_t4", int'(SegEn), 4'b0011);
    step(4);
    chk("up_t8", int'(SegEn), 4'b0111);
    step(4);
    chk("up_t12", int'(SegEn), 4'b1111);
    step(3);
    chk("up_t15_rdy", int'(PclkRdy), 0);
    chk("up_t15_busy", int'(Busy), 1);
    step(1);
    chk("up_t16_rdy", int'(PclkRdy), 1);
    chk("up_t16_busy", int'(Busy), 0);

    // Ramp down, settle 3
    SettleDly = 6'd3;
    EnReq = 1'b0;
    step(1);
    chk("dn_e0_rdy", int'(PclkRdy), 0);
    chk("dn_e0_seg", int'(SegEn), 4'b1111);
    step(4);
    chk("dn_e4", int'(SegEn), 4'b0111);
    step(4);
    chk("dn_e8", int'(SegEn), 4'b0011);
    step(4);
    chk("dn_e12", int'(SegEn), 4'b0001);
    step(4);
    chk("dn_e16", int'(SegEn), 4'b0000);
    chk("dn_busy", int'(Busy), 0);

    // Zero settle gap
    SettleDly = 6'd0;
    EnReq = 1'b1;
    step(1);
    chk("z_t0", int'(SegEn), 4'b0001);
    step(1);
    chk("z_t1", int'(SegEn), 4'b0011);
    step(1);
    chk("z_t2", int'(SegEn), 4'b0111);
    step(1);
    chk("z_t3", int'(SegEn), 4'b1111);
    chk("z_t3_rdy", int'(PclkRdy), 0);
    step(1);
    chk("z_t4_rdy", int'(PclkRdy), 1);

    // Supply loss while ON
    PwrOk = 1'b0;
    step(2);
    chk("pf_e2_rdy", int'(PclkRdy), 1);
    step(1);
    chk("pf_e3_seg", int'(SegEn), 0);
    chk("pf_e3_rdy", int'(PclkRdy), 0);
    chk("pf_e3_flt", int'(PwrFault), 1);
    PwrOk = 1'b1;
    step(6);
    chk("pf_hold", int'(PwrFault), 1);
    chk("pf_hold_seg", int'(SegEn), 0);
    EnReq = 1'b0;
    step(1);
    chk("pf_clr", int'(PwrFault), 0);
    SettleDly = 6'd3;
    EnReq = 1'b1;
    step(1);
    chk("rs_t0", int'(SegEn), 4'b0001);
    step(4);
    chk("rs_t4", int'(SegEn), 4'b0011);

    // Abort mid-ramp at 0011
    EnReq = 1'b0;
    step(4);
    chk("ab_hold", int'(SegEn), 4'b0011);
    step(1);
    chk("ab_d4", int'(SegEn), 4'b0001);
    step(3);
    chk("ab_d7", int'(SegEn), 4'b0001);
    step(1);
    chk("ab_d8", int'(SegEn), 4'b0000);
    chk("ab_busy", int'(Busy), 0);

    // Async reset mid-ramp
    EnReq = 1'b1;
    step(6);
    chk("ar_pre", int'(SegEn), 4'b0011);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_seg", int'(SegEn), 0);
    chk("ar_busy", int'(Busy), 0);
    chk("ar_rdy", int'(PclkRdy), 0);
    chk("ar_flt", int'(PwrFault), 0);
    EnReq = 1'b0;
    step(1);
    Reset_n = 1'b1;
    step(3);

    // Random traffic
    pdrop = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) EnReq = ~EnReq;
      SettleDly = DW'($urandom_range(0, 5));
      if (pdrop > 0) begin
        pdrop--;
        PwrOk = (pdrop == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        pdrop = $urandom_range(1, 6);
        PwrOk = 1'b0;
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
